// File: rtl/dual_mem_sum_sequencer.sv
// Burst reader for two single-port memories; accumulates the word-wise sum.
// Optional macro SUM_SATURATE_EN: saturate sum at all-ones instead of wrapping.
module dual_mem_sum_sequencer #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 4,
    parameter int SUM_W     = 16,
    parameter int NUM_WORDS = 8,
    parameter int RD_LAT    = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] dout1,
    input  logic [DATA_W-1:0] dout2,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            r_state;
    logic [RD_LAT:0]   r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ena;
    logic              r_busy;
    logic              r_done;
    logic [SUM_W-1:0]  r_sum;

    logic [DATA_W:0]   w_pair;
    logic [SUM_W-1:0]  w_next;
    logic              w_acc;
    logic              w_last;

    assign w_pair = {1'b0, dout1} + {1'b0, dout2};

`ifdef SUM_SATURATE_EN
    logic [SUM_W:0] w_wide;
    assign w_wide = {1'b0, r_sum} + (SUM_W + 1)'(w_pair);
    assign w_next = w_wide[SUM_W] ? {SUM_W{1'b1}} : w_wide[SUM_W-1:0];
`else
    assign w_next = r_sum + SUM_W'(w_pair);
`endif

    // The oldest valid slot marks the cycle its memory word is on dout.
    assign w_acc  = r_vld[RD_LAT];
    // Last word: draining and no younger reads still in flight.
    assign w_last = w_acc && (r_state == S_DRAIN)
                    && (r_vld[RD_LAT-1:0] == '0);

    // Burst FSM, address issue, valid pipeline and accumulator.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_vld   <= '0;
            r_addr  <= '0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
        end else begin
            r_vld <= {r_vld[RD_LAT-1:0], 1'b0};
            if (w_acc && (r_state != S_IDLE)) begin
                r_sum <= w_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_READ;
                        r_addr   <= '0;
                        r_ena    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_sum    <= '0;
                        r_vld[0] <= 1'b1;
                    end
                end
                S_READ: begin
                    if (r_addr == LAST_ADDR) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr   <= r_addr + 1'b1;
                        r_vld[0] <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_ena   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ena     = r_ena;
    assign wea     = 1'b0;
    assign address = r_addr;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sum     = r_sum;

endmodule

// File: tb/tb_dual_mem_sum_sequencer.sv
// Directed bench: default build, RD_LAT=2 build, and narrow SUM_W=7 build.
// Expected sums hand-computed from the memory contents.
module tb_dual_mem_sum_sequencer;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic a_start = 1'b0;
    logic b_start = 1'b0;
    logic c_start = 1'b0;

    int checks   = 0;
    int failures = 0;
    bit wea_seen = 1'b0;

    logic [3:0] m1 [8];
    logic [3:0] m2 [8];

    // instance A: defaults
    logic [3:0]  a_d1, a_d2;
    logic        a_ena, a_wea, a_busy, a_done;
    logic [2:0]  a_addr;
    logic [15:0] a_sum;
    // instance B: RD_LAT=2
    logic [3:0]  b_p1, b_p2, b_d1, b_d2;
    logic        b_ena, b_wea, b_busy, b_done;
    logic [2:0]  b_addr;
    logic [15:0] b_sum;
    // instance C: SUM_W=7
    logic [3:0]  c_d1, c_d2;
    logic        c_ena, c_wea, c_busy, c_done;
    logic [2:0]  c_addr;
    logic [6:0]  c_sum;

    dual_mem_sum_sequencer u_a (
        .clock(clock), .clear(clear), .start(a_start),
        .dout1(a_d1), .dout2(a_d2), .ena(a_ena), .wea(a_wea),
        .address(a_addr), .busy(a_busy), .done(a_done), .sum(a_sum)
    );

    dual_mem_sum_sequencer #(.RD_LAT(2)) u_b (
        .clock(clock), .clear(clear), .start(b_start),
        .dout1(b_d1), .dout2(b_d2), .ena(b_ena), .wea(b_wea),
        .address(b_addr), .busy(b_busy), .done(b_done), .sum(b_sum)
    );

    dual_mem_sum_sequencer #(.SUM_W(7)) u_c (
        .clock(clock), .clear(clear), .start(c_start),
        .dout1(c_d1), .dout2(c_d2), .ena(c_ena), .wea(c_wea),
        .address(c_addr), .busy(c_busy), .done(c_done), .sum(c_sum)
    );

    always #5 clock = ~clock;

    // memory models: registered output, latency 1 (A, C) and 2 (B)
    always @(posedge clock) begin
        if (a_ena) begin
            a_d1 <= m1[a_addr];
            a_d2 <= m2[a_addr];
        end
        if (c_ena) begin
            c_d1 <= m1[c_addr];
            c_d2 <= m2[c_addr];
        end
        if (b_ena) begin
            b_p1 <= m1[b_addr];
            b_p2 <= m2[b_addr];
        end
        b_d1 <= b_p1;
        b_d2 <= b_p2;
    end

    always @(negedge clock) begin
        if (a_wea !== 1'b0 || b_wea !== 1'b0 || c_wea !== 1'b0)
            wea_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 8; i++) begin
            m1[i] = 4'(i);
            m2[i] = 4'(2 * i);
        end
    endtask

    // One burst on A; start sampled at edge k, n counts edges after k.
    task automatic burst_a(input string tag, input int exp_sum,
                           input bit hold);
        a_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold) a_start = 1'b0;
        chk({tag, "_sum_clr"}, a_sum, 0);
        for (int n = 0; n <= 10; n++) begin
            if (n <= 7) chk({tag, "_addr"}, a_addr, n);
            chk({tag, "_done"}, a_done, (n == 9));
            chk({tag, "_busy"}, a_busy, (n <= 9));
            if (n == 9) chk({tag, "_sum"}, a_sum, exp_sum);
            if (n == 8) chk({tag, "_ena8"}, a_ena, 1);
            if (n == 9) chk({tag, "_ena9"}, a_ena, 0);
            if (n < 10) @(negedge clock);
        end
        chk({tag, "_sum_hold"}, a_sum, exp_sum);
    endtask

    initial begin
        set_ramp();
        repeat (2) @(negedge clock);
        clear = 1'b0;

        // reset state
        chk("rst_ena", a_ena, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_sum", a_sum, 0);
        chk("rst_addr", a_addr, 0);

        // scenario 1: ramp data, sum 84
        burst_a("s1", 84, 1'b0);

        // scenario 2: all 0xF then mem2 zero
        for (int i = 0; i < 8; i++) begin
            m1[i] = 4'hF;
            m2[i] = 4'hF;
        end
        burst_a("s2a", 240, 1'b0);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 8; i++) m2[i] = 4'h0;
        burst_a("s2b", 120, 1'b0);

        // scenario 3: clear at edge k+4 mid-burst
        set_ramp();
        @(negedge clock);
        a_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a_start = 1'b0;
        repeat (3) @(negedge clock);
        chk("s3_partial", (a_sum != 0), 1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("s3_addr", a_addr, 0);
        chk("s3_ena", a_ena, 0);
        chk("s3_busy", a_busy, 0);
        chk("s3_sum", a_sum, 0);
        for (int n = 0; n < 12; n++) begin
            chk("s3_nodone", a_done, 0);
            @(negedge clock);
        end
        burst_a("s3b", 84, 1'b0);

        // scenario 4: start held high, back-to-back bursts
        @(negedge clock);
        burst_a("s4a", 84, 1'b1);
        burst_a("s4b", 84, 1'b1);
        burst_a("s4c", 84, 1'b1);
        a_start = 1'b0;
        @(negedge clock);
        chk("s4_idle_busy", a_busy, 0);

        // scenario 5: RD_LAT=2, done one cycle later
        b_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        b_start = 1'b0;
        for (int n = 0; n <= 11; n++) begin
            if (n <= 7) chk("s5_addr", b_addr, n);
            chk("s5_done", b_done, (n == 10));
            if (n == 10) chk("s5_sum", b_sum, 84);
            if (n == 11) chk("s5_busy", b_busy, 0);
            if (n < 11) @(negedge clock);
        end

        // scenario 6: SUM_W=7 with all 0xF data
        for (int i = 0; i < 8; i++) begin
            m1[i] = 4'hF;
            m2[i] = 4'hF;
        end
        @(negedge clock);
        c_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        c_start = 1'b0;
        for (int n = 0; n <= 9; n++) begin
            chk("s6_done", c_done, (n == 9));
`ifdef SUM_SATURATE_EN
            if (n == 9) chk("s6_sum_sat", c_sum, 127);
`else
            if (n == 9) chk("s6_sum_wrap", c_sum, 112);
`endif
            if (n < 9) @(negedge clock);
        end

        chk("wea_never", wea_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
